// File: rtl/blowfish128_ffunc_arbiter.sv
// Shares one Blowfish-128 F-function unit between two cores over a level en/rdy handshake.
// Latency: rdy = F-unit latency + 2 cycles after en; a losing requester holds en until granted.
module blowfish128_ffunc_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        Clk,
   input  logic        RstN,
   input  logic        req0_en,
   input  logic [63:0] req0_x,
   output logic [63:0] req0_y,
   output logic        req0_rdy,
   input  logic        req1_en,
   input  logic [63:0] req1_x,
   output logic [63:0] req1_y,
   output logic        req1_rdy,
   output logic        ff_start,
   output logic [63:0] ff_x,
   input  logic        ff_done,
   input  logic [63:0] ff_y,
   output logic [1:0]  gnt,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_RELEASE
   } state_t;

   localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYC);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_ptr;
   logic [1:0]  r_gnt;
   logic        r_ff_start;
   logic [63:0] r_ff_x;
   logic [63:0] r_req0_y;
   logic [63:0] r_req1_y;
   logic        r_req0_rdy;
   logic        r_req1_rdy;
   logic        r_tmo_err;
   logic [7:0]  r_cnt;

   logic        w_any_req;
   logic        w_sel;
   logic        w_own_en;
   logic [7:0]  w_cnt_inc;
   logic        w_tmo;
   logic        w_finish;
   logic [63:0] w_res;

   assign w_any_req = req0_en | req1_en;
   // Contention goes to the pointer; otherwise whoever is asking.
   assign w_sel     = (req0_en & req1_en) ? r_ptr : req1_en;
   assign w_own_en  = r_gnt[1] ? req1_en : req0_en;
   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_tmo     = (w_cnt_inc == LP_TMO);
   assign w_finish  = ff_done | w_tmo;
   // A completion on the timeout edge wins, so real data beats the abort value.
   assign w_res     = ff_done ? ff_y : 64'h0;

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_any_req) w_state_nxt = S_ISSUE;
         S_ISSUE:   w_state_nxt = S_WAIT;
         S_WAIT:    if (w_finish) w_state_nxt = S_RESP;
         S_RESP:    w_state_nxt = S_RELEASE;
         S_RELEASE: if (!w_own_en) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         r_ptr      <= 1'b0;
         r_gnt      <= 2'b00;
         r_ff_start <= 1'b0;
         r_ff_x     <= 64'h0;
         r_req0_y   <= 64'h0;
         r_req1_y   <= 64'h0;
         r_req0_rdy <= 1'b0;
         r_req1_rdy <= 1'b0;
         r_tmo_err  <= 1'b0;
         r_cnt      <= 8'd0;
      end else begin
         r_ff_start <= 1'b0;
         r_req0_rdy <= 1'b0;
         r_req1_rdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_gnt      <= w_sel ? 2'b10 : 2'b01;
                  r_ff_x     <= w_sel ? req1_x : req0_x;
                  r_ff_start <= 1'b1;
               end
            end
            S_ISSUE: begin
               r_cnt <= 8'd0;
            end
            S_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (w_finish) begin
                  if (r_gnt[1]) begin
                     r_req1_y   <= w_res;
                     r_req1_rdy <= 1'b1;
                  end else begin
                     r_req0_y   <= w_res;
                     r_req0_rdy <= 1'b1;
                  end
                  if (!ff_done) r_tmo_err <= 1'b1;
               end
            end
            S_RESP: begin
               r_ptr <= ~r_gnt[1];
            end
            S_RELEASE: begin
               if (!w_own_en) r_gnt <= 2'b00;
            end
            default: begin
               r_gnt <= 2'b00;
            end
         endcase
      end
   end

   assign req0_y      = r_req0_y;
   assign req0_rdy    = r_req0_rdy;
   assign req1_y      = r_req1_y;
   assign req1_rdy    = r_req1_rdy;
   assign ff_start    = r_ff_start;
   assign ff_x        = r_ff_x;
   assign gnt         = r_gnt;
   assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_blowfish128_ffunc_arbiter.sv
// Directed bench for the shared F-unit arbiter; the F-unit is played inline by each test.
module tb_blowfish128_ffunc_arbiter;

   logic        Clk = 1'b0;
   logic        RstN;
   logic        req0_en, req1_en;
   logic [63:0] req0_x, req1_x;
   logic [63:0] req0_y, req1_y;
   logic        req0_rdy, req1_rdy;
   logic        ff_start;
   logic [63:0] ff_x;
   logic        ff_done;
   logic [63:0] ff_y;
   logic [1:0]  gnt;
   logic        timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   blowfish128_ffunc_arbiter #(.TIMEOUT_CYC(4)) dut (
      .Clk(Clk), .RstN(RstN),
      .req0_en(req0_en), .req0_x(req0_x), .req0_y(req0_y), .req0_rdy(req0_rdy),
      .req1_en(req1_en), .req1_x(req1_x), .req1_y(req1_y), .req1_rdy(req1_rdy),
      .ff_start(ff_start), .ff_x(ff_x), .ff_done(ff_done), .ff_y(ff_y),
      .gnt(gnt), .timeout_err(timeout_err)
   );

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge Clk);
   endtask

   task automatic do_reset;
      RstN = 1'b0; req0_en = 1'b0; req1_en = 1'b0; ff_done = 1'b0; ff_y = 64'h0;
      req0_x = 64'h0; req1_x = 64'h0;
      cyc(2);
      RstN = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      RstN = 1'b0;
      cyc(1);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_checks++; if (ff_start !== 1'b0) begin n_fail++; $display("FAIL reset_ff_start: got %b want 0", ff_start); end
      n_checks++; if ({req0_rdy, req1_rdy} !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b want 00", {req0_rdy, req1_rdy}); end
      n_checks++; if (ff_x !== 64'h0) begin n_fail++; $display("FAIL reset_ff_x: got %h want 0", ff_x); end
      n_checks++; if ({req0_y, req1_y} !== 128'h0) begin n_fail++; $display("FAIL reset_y: got %h %h want 0", req0_y, req1_y); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
      RstN = 1'b1;
   endtask

   task automatic test_single;
      do_reset();
      req0_x = 64'h0123456789ABCDEF; req0_en = 1'b1;
      cyc(1);
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", gnt); end
      n_checks++; if (ff_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", ff_start); end
      n_checks++; if (ff_x !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL single_ff_x: got %h want 0123456789abcdef", ff_x); end
      cyc(1);
      n_checks++; if (ff_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b want 0", ff_start); end
      cyc(2);
      n_checks++; if (req0_rdy !== 1'b0) begin n_fail++; $display("FAIL single_rdy_early: got %b want 0", req0_rdy); end
      ff_done = 1'b1; ff_y = 64'hDEADBEEF00000001;
      cyc(1);
      ff_done = 1'b0; ff_y = 64'h0;
      n_checks++; if (req0_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %b want 1", req0_rdy); end
      n_checks++; if (req0_y !== 64'hDEADBEEF00000001) begin n_fail++; $display("FAIL single_y: got %h want deadbeef00000001", req0_y); end
      n_checks++; if (req1_rdy !== 1'b0) begin n_fail++; $display("FAIL single_rdy1: got %b want 0", req1_rdy); end
      req0_en = 1'b0;
      cyc(1);
      n_checks++; if (req0_rdy !== 1'b0 || gnt !== 2'b01) begin n_fail++; $display("FAIL single_resp: got rdy=%b gnt=%b want 0 01", req0_rdy, gnt); end
      cyc(1);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", gnt); end
      n_checks++; if (req0_y !== 64'hDEADBEEF00000001 || ff_x !== 64'h0123456789ABCDEF) begin
         n_fail++; $display("FAIL single_hold: got y=%h x=%h", req0_y, ff_x); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] exp_y;
      logic [1:0]  exp_gnt;
      do_reset();
      req0_x = 64'h1111111111111111; req1_x = 64'h2222222222222222;
      req0_en = 1'b1; req1_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
         exp_y   = 64'hA0 + 64'(k);
         cyc(1);
         n_checks++; if (gnt !== exp_gnt || ff_start !== 1'b1) begin
            n_fail++; $display("FAIL alt_gnt[%0d]: got gnt=%b start=%b want %b 1", k, gnt, ff_start, exp_gnt); end
         n_checks++; if (ff_x !== (exp_gnt[1] ? 64'h2222222222222222 : 64'h1111111111111111)) begin
            n_fail++; $display("FAIL alt_ff_x[%0d]: got %h", k, ff_x); end
         cyc(1);
         ff_done = 1'b1; ff_y = exp_y;
         cyc(1);
         ff_done = 1'b0;
         n_checks++; if ({req1_rdy, req0_rdy} !== exp_gnt) begin
            n_fail++; $display("FAIL alt_rdy[%0d]: got %b want %b", k, {req1_rdy, req0_rdy}, exp_gnt); end
         n_checks++; if ((exp_gnt[1] ? req1_y : req0_y) !== exp_y) begin
            n_fail++; $display("FAIL alt_y[%0d]: got %h want %h", k, exp_gnt[1] ? req1_y : req0_y, exp_y); end
         if (exp_gnt[1]) req1_en = 1'b0; else req0_en = 1'b0;
         cyc(2);
         n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL alt_idle[%0d]: got %b want 00", k, gnt); end
         req0_en = 1'b1; req1_en = 1'b1;
      end
      req0_en = 1'b0; req1_en = 1'b0;
      cyc(3);
   endtask

   task automatic test_timeout;
      do_reset();
      req1_x = 64'h0F0F0F0F0F0F0F0F; req1_en = 1'b1;
      cyc(1);
      n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL tmo_pre_gnt: got %b want 10", gnt); end
      cyc(1);
      ff_done = 1'b1; ff_y = 64'h5555AAAA5555AAAA;
      cyc(1);
      ff_done = 1'b0;
      n_checks++; if (req1_rdy !== 1'b1 || req1_y !== 64'h5555AAAA5555AAAA) begin
         n_fail++; $display("FAIL tmo_pre_y: got rdy=%b y=%h", req1_rdy, req1_y); end
      req1_en = 1'b0;
      cyc(2);
      req1_en = 1'b1;
      cyc(1);
      n_checks++; if (ff_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", ff_start); end
      cyc(4);
      n_checks++; if (req1_rdy !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL tmo_early: got rdy=%b err=%b want 0 0", req1_rdy, timeout_err); end
      cyc(1);
      n_checks++; if (req1_rdy !== 1'b1 || req0_rdy !== 1'b0) begin
         n_fail++; $display("FAIL tmo_rdy: got rdy1=%b rdy0=%b want 1 0", req1_rdy, req0_rdy); end
      n_checks++; if (req1_y !== 64'h0) begin n_fail++; $display("FAIL tmo_y: got %h want 0", req1_y); end
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", timeout_err); end
      req1_en = 1'b0;
      cyc(2);
      req0_x = 64'h3; req0_en = 1'b1;
      cyc(2);
      ff_done = 1'b1; ff_y = 64'h77;
      cyc(1);
      ff_done = 1'b0;
      n_checks++; if (req0_rdy !== 1'b1 || req0_y !== 64'h77 || timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL tmo_sticky: got rdy=%b y=%h err=%b want 1 77 1", req0_rdy, req0_y, timeout_err); end
      req0_en = 1'b0;
      cyc(2);
      do_reset();
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared: got %b want 0", timeout_err); end
   endtask

   task automatic test_coincident;
      do_reset();
      req0_x = 64'h4444; req0_en = 1'b1;
      cyc(5);
      n_checks++; if (req0_rdy !== 1'b0) begin n_fail++; $display("FAIL coin_early: got %b want 0", req0_rdy); end
      ff_done = 1'b1; ff_y = 64'hC0FFEE00C0FFEE00;
      cyc(1);
      ff_done = 1'b0;
      n_checks++; if (req0_rdy !== 1'b1 || req0_y !== 64'hC0FFEE00C0FFEE00) begin
         n_fail++; $display("FAIL coin_y: got rdy=%b y=%h want 1 c0ffee00c0ffee00", req0_rdy, req0_y); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL coin_err: got %b want 0", timeout_err); end
      req0_en = 1'b0;
      cyc(2);
   endtask

   task automatic test_reset_mid;
      do_reset();
      req1_x = 64'h99; req1_en = 1'b1;
      cyc(2);
      ff_done = 1'b1; ff_y = 64'h1234;
      cyc(1);
      ff_done = 1'b0;
      req1_en = 1'b0;
      cyc(2);
      req1_en = 1'b1;
      cyc(3);
      RstN = 1'b0; req1_en = 1'b0;
      cyc(1);
      RstN = 1'b1;
      n_checks++; if ({gnt, ff_start, req0_rdy, req1_rdy, timeout_err} !== 6'b0) begin
         n_fail++; $display("FAIL rmid_ctrl: got gnt=%b st=%b r0=%b r1=%b err=%b want 0", gnt, ff_start, req0_rdy, req1_rdy, timeout_err); end
      n_checks++; if ({ff_x, req0_y, req1_y} !== 192'h0) begin
         n_fail++; $display("FAIL rmid_data: got x=%h y0=%h y1=%h want 0", ff_x, req0_y, req1_y); end
      ff_done = 1'b1; ff_y = 64'hBAD;
      cyc(1);
      ff_done = 1'b0;
      cyc(1);
      n_checks++; if ({req0_rdy, req1_rdy} !== 2'b00 || req1_y !== 64'h0 || gnt !== 2'b00) begin
         n_fail++; $display("FAIL rmid_late_done: got rdy=%b y1=%h gnt=%b", {req0_rdy, req1_rdy}, req1_y, gnt); end
      req0_x = 64'h5; req0_en = 1'b1;
      cyc(1);
      n_checks++; if (gnt !== 2'b01 || ff_start !== 1'b1 || ff_x !== 64'h5) begin
         n_fail++; $display("FAIL rmid_next_gnt: got gnt=%b st=%b x=%h", gnt, ff_start, ff_x); end
      cyc(1);
      ff_done = 1'b1; ff_y = 64'h55;
      cyc(1);
      ff_done = 1'b0;
      n_checks++; if (req0_rdy !== 1'b1 || req0_y !== 64'h55) begin
         n_fail++; $display("FAIL rmid_next_y: got rdy=%b y=%h want 1 55", req0_rdy, req0_y); end
      req0_en = 1'b0;
      cyc(2);
   endtask

   task automatic test_drop_en;
      do_reset();
      req0_x = 64'h6; req0_en = 1'b1;
      cyc(2);
      req0_en = 1'b0;
      cyc(1);
      ff_done = 1'b1; ff_y = 64'hFEEDFACE;
      cyc(1);
      ff_done = 1'b0;
      n_checks++; if (req0_rdy !== 1'b1 || req0_y !== 64'hFEEDFACE) begin
         n_fail++; $display("FAIL drop_rdy: got rdy=%b y=%h want 1 feedface", req0_rdy, req0_y); end
      cyc(1);
      n_checks++; if (req0_rdy !== 1'b0 || gnt !== 2'b01) begin
         n_fail++; $display("FAIL drop_release: got rdy=%b gnt=%b want 0 01", req0_rdy, gnt); end
      cyc(1);
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL drop_idle: got %b want 00", gnt); end
      ff_done = 1'b1; ff_y = 64'h0BADBAD0;
      cyc(1);
      ff_done = 1'b0;
      cyc(1);
      n_checks++; if ({ff_start, req0_rdy, req1_rdy, gnt} !== 5'b0 || req0_y !== 64'hFEEDFACE) begin
         n_fail++; $display("FAIL drop_spurious: got st=%b r0=%b r1=%b gnt=%b y0=%h", ff_start, req0_rdy, req1_rdy, gnt, req0_y); end
   endtask

   initial begin
      RstN = 1'b0; req0_en = 1'b0; req1_en = 1'b0; ff_done = 1'b0; ff_y = 64'h0;
      req0_x = 64'h0; req1_x = 64'h0;
      cyc(1);
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_coincident();
      test_reset_mid();
      test_drop_en();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/blowfish128_ffunc_arbiter.md
BLOWFISH128_FFUNC_ARBITER -- requirements
Module: blowfish128_ffunc_arbiter

Interface
REQ-001 The block SHALL have a single clock, Clk, and a synchronous active-low reset, RstN, sampled only on the rising edge of Clk.
REQ-002 Parameter: TIMEOUT_CYC, 64, maximum WAIT cycles before abort; the legal range SHALL be 2..255.
REQ-003 The port list SHALL be as follows:
- Clk  in  1  clock
- RstN  in  1  synchronous active-low reset
- req0_en  in  1  requester 0 F-function request, level
- req0_x  in  64  requester 0 F-function operand
- req0_y  out  64  requester 0 result
- req0_rdy  out  1  requester 0 result-valid pulse
- req1_en  in  1  requester 1 request, level
- req1_x  in  64  requester 1 operand
- req1_y  out  64  requester 1 result
- req1_rdy  out  1  requester 1 result-valid pulse
- ff_start  out  1  shared F-unit start pulse
- ff_x  out  64  shared F-unit operand
- ff_done  in  1  shared F-unit completion pulse
- ff_y  in  64  shared F-unit result, valid with ff_done
- gnt  out  2  one-hot current owner; 00 means none
- timeout_err  out  1  sticky: an F-unit call timed out

Function
REQ-004 The block SHALL share one F-function unit between two Blowfish-128 cores using the core-side level handshake: en is held high until rdy is seen, then dropped.
REQ-005 All outputs SHALL be registered.
REQ-006 The block SHALL implement the states IDLE, ISSUE, WAIT, RESP and RELEASE.
REQ-007 In IDLE with any reqN_en sampled high, the block SHALL select the owner:
- only one en high: that requester;
- both high: the requester named by the priority pointer.
REQ-008 On the IDLE selection edge, the block SHALL set gnt one-hot, latch the owner's x into ff_x, and go to ISSUE.
REQ-009 In ISSUE, ff_start SHALL be high for exactly one cycle; the block SHALL then go to WAIT with the timeout counter cleared.
REQ-010 ff_x SHALL hold its value from ISSUE until the next grant.
REQ-011 In WAIT, the block SHALL count cycles; ff_done high SHALL latch ff_y into the owner's reqN_y and go to RESP.
REQ-012 ff_done outside WAIT SHALL be ignored.
REQ-013 If the counter reaches TIMEOUT_CYC without ff_done, the block SHALL set timeout_err, load 64'h0 into the owner's reqN_y, and go to RESP.
REQ-014 ff_done on the same edge the counter reaches TIMEOUT_CYC SHALL be treated as completion; timeout_err SHALL be unchanged.
REQ-015 In RESP, the owner's reqN_rdy SHALL be high for exactly one cycle and the priority pointer SHALL move to the other requester; the block SHALL then go to RELEASE.
REQ-016 In RELEASE, the block SHALL wait until the owner's en is sampled low, then go to IDLE with gnt=00.
REQ-017 A new grant SHALL NOT occur in the cycle RELEASE exits.
REQ-018 reqN_y SHALL hold its last value until overwritten by that requester's next transaction.
REQ-019 The non-owner's rdy SHALL stay 0 and its pending en SHALL wait; it SHALL be granted at the next IDLE.
REQ-020 If the owner drops en during ISSUE or WAIT, the transaction SHALL NOT be aborted: RESP SHALL still pulse rdy, and RELEASE SHALL exit on its first cycle.
REQ-021 Latency SHALL be fixed:
- ff_start SHALL be high in the cycle after the IDLE selection edge;
- reqN_rdy SHALL be high in the cycle after the edge sampling ff_done;
- en-to-rdy = F-unit latency + 2 cycles.
REQ-022 Back-to-back alternation SHALL be guaranteed: a pending request from the other requester SHALL be granted before a repeat from the last owner.

Reset
REQ-023 When RstN is sampled low, the following SHALL apply:
- state = IDLE; priority pointer = requester 0;
- gnt=00, ff_start=0, req0_rdy=0, req1_rdy=0;
- ff_x, req0_y, req1_y = 64'h0; timeout counter = 0; timeout_err = 0.
REQ-024 Reset mid-transaction SHALL discard the transaction without any rdy pulse; an ff_done arriving after reset SHALL be ignored.

Verification
REQ-025 Single request: req0_en=1, req0_x=64'h0123456789ABCDEF, F-unit returns 64'hDEADBEEF00000001 after 3 cycles -> ff_x matches; one ff_start pulse; req0_rdy one-cycle pulse 5 cycles after en; req0_y=64'hDEADBEEF00000001; gnt=01 then 00.
REQ-026 Simultaneous requests after reset -> req0 served first, then req1. With both then held requesting -> grants alternate 01,10,01.
REQ-027 Timeout: TIMEOUT_CYC=4, F-unit never answers -> req1_rdy pulses with req1_y=0; timeout_err=1 stays set until reset.
REQ-028 ff_done coincident with the timeout edge -> real ff_y delivered; timeout_err stays 0.
REQ-029 Reset asserted in WAIT, then late ff_done -> no rdy pulse; all outputs zero; the next request proceeds normally.
REQ-030 Owner drops en during WAIT -> rdy still pulses once; IDLE is reached 1 cycle after RESP; a spurious ff_done in IDLE produces no effect.
